// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store front-end between the execute stage and a word-only data SRAM.
//   Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into SRAM word accesses.
//   Loads are sign/zero-extended. Misaligned requests are rejected with a pulse.
//   Sub-word stores are done as read-modify-write. The upstream stage is
//   stalled while an access is in flight.
//
// Build option:
//   MAU_BYTE_WE_EN - adds sram_wmask[3:0]. Sub-word stores then finish in one
//                    cycle through the byte mask, and the RMW sequence is not
//                    used.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   req_valid   request present (accepted only when idle)
//   req_store   1 = store, 0 = load
//   req_funct3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU; others = W)
//   req_addr    byte address
//   req_wdata   store data, LSB-aligned
//   req_rd      load destination register
//   stall       high while busy; upstream holds its request
//   sram_addr   SRAM word address
//   sram_din    SRAM write data
//   sram_web    SRAM write enable, active-low
//   sram_wmask  SRAM byte-write mask (MAU_BYTE_WE_EN builds only)
//   sram_dout   SRAM read data, valid one cycle after the address
//   ld_valid    one-cycle pulse: load result ready
//   ld_data     extended load result
//   ld_rd       destination register of the load
//   st_done     one-cycle pulse: store committed to SRAM
//   misalign    one-cycle pulse: request rejected as misaligned
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_web,
`ifdef MAU_BYTE_WE_EN
  output logic [3:0]            sram_wmask,
`endif
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [4:0]            ld_rd,
  output logic                  st_done,
  output logic                  misalign
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WAIT  = 2'd2;
  localparam logic [1:0] RMW_WRITE = 2'd3;

  // Lane extraction with sign (f3[2]=0) or zero (f3[2]=1) extension.
  // funct3[1:0]: 00 byte, 01 halfword, anything else is a full word.
  function automatic logic [DATA_WIDTH-1:0] extend_load(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [2:0]            f3
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   extend_load = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   extend_load = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

  // Insert the new byte/halfword into the word read back from the SRAM.
  function automatic logic [DATA_WIDTH-1:0] merge_store(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [2:0]            f3,
    input logic [DATA_WIDTH-1:0] wdata
  );
    merge_store = word;
    if (f3[1:0] == 2'b00) merge_store[{off, 3'b000} +: 8]    = wdata[7:0];
    else                  merge_store[{off[1], 4'b0000} +: 16] = wdata[15:0];
  endfunction

  // Registered state
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic                  ld_valid_q, ld_valid_d;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
  logic [4:0]            ld_rd_q, ld_rd_d;
  logic                  st_done_q, st_done_d;
  logic                  misalign_q, misalign_d;

  // Request decode (only meaningful in IDLE)
  logic is_byte, is_half, is_word, is_mis, accept, go;

  assign is_byte = (req_funct3[1:0] == 2'b00);
  assign is_half = (req_funct3[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;
  assign is_mis  = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign accept  = req_valid && (state_q == IDLE);
  assign go      = accept && !is_mis;

  // Address bits above the SRAM size are deliberately dropped (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default here so no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    ld_rd_d    = ld_rd_q;
    st_done_d  = 1'b0;
    misalign_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr[ADDR_WIDTH+1:2];
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          rd_d    = req_rd;
          wdata_d = req_wdata;
          if (is_mis) begin
            misalign_d = 1'b1;
          end else if (!req_store) begin
            state_d = LOAD_WAIT;
`ifdef MAU_BYTE_WE_EN
          end else begin
            // Every store is written directly through the byte mask.
            st_done_d = 1'b1;
          end
`else
          end else if (is_word) begin
            st_done_d = 1'b1;
          end else begin
            state_d = RMW_WAIT;
          end
`endif
        end
      end
      LOAD_WAIT: begin
        ld_data_d  = extend_load(sram_dout, off_q, f3_q);
        ld_rd_d    = rd_q;
        ld_valid_d = 1'b1;
        state_d    = IDLE;
      end
      RMW_WAIT: begin
        merged_d = merge_store(sram_dout, off_q, f3_q, wdata_q);
        state_d  = RMW_WRITE;
      end
      RMW_WRITE: begin
        st_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM-side outputs. Writes are suppressed while reset is asserted so an
  // in-flight RMW can never commit.
  always_comb begin
    sram_web = 1'b1;
    sram_din = req_wdata;
`ifdef MAU_BYTE_WE_EN
    sram_wmask = 4'b1111;
`endif
    if (rst) begin
      if (state_q == RMW_WRITE) begin
        sram_web = 1'b0;
        sram_din = merged_q;
      end else if (go && req_store) begin
`ifdef MAU_BYTE_WE_EN
        sram_web = 1'b0;
        if (is_byte) begin
          sram_din   = {4{req_wdata[7:0]}};
          sram_wmask = 4'b0001 << req_addr[1:0];
        end else if (is_half) begin
          sram_din   = {2{req_wdata[15:0]}};
          sram_wmask = 4'b0011 << req_addr[1:0];
        end
`else
        sram_web = !is_word;
`endif
      end
    end
  end

  assign sram_addr = (state_q == IDLE) ? req_addr[ADDR_WIDTH+1:2] : addr_q;
  assign stall     = (state_q != IDLE);
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign ld_rd     = ld_rd_q;
  assign st_done   = st_done_q;
  assign misalign  = misalign_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      ld_rd_q    <= '0;
      st_done_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      ld_rd_q    <= ld_rd_d;
      st_done_q  <= st_done_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: request latches are pure datapath, always written before use, so
  // they are left out of reset.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    off_q    <= off_d;
    f3_q     <= f3_d;
    rd_q     <= rd_d;
    wdata_q  <= wdata_d;
    merged_q <= merged_d;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int K_LOAD = 0;
  localparam int K_SW   = 1;
  localparam int K_RMW  = 2;
  localparam int K_MIS  = 3;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          kind;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, sram_web, ld_valid, st_done, misalign;
  logic [4:0]  sram_addr, ld_rd;
  logic [31:0] sram_din, sram_dout, ld_data;
`ifdef MAU_BYTE_WE_EN
  logic [3:0]  sram_wmask;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .sram_addr(sram_addr), .sram_din(sram_din), .sram_web(sram_web),
`ifdef MAU_BYTE_WE_EN
    .sram_wmask(sram_wmask),
`endif
    .sram_dout(sram_dout), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .st_done(st_done), .misalign(misalign)
  );

  // SRAM model: synchronous read, one cycle latency.
  logic [31:0] mem [32];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem_init <= 1'b1;
    end else if (!sram_web) begin
`ifdef MAU_BYTE_WE_EN
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
`else
      mem[sram_addr] <= sram_din;
`endif
    end
    sram_dout <= mem[sram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input int kind, input logic [31:0] exp);
    vec_t v;
    v.store = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.kind = kind; v.exp = exp;
    return v;
  endfunction

  // Issue one request, then watch five cycles and check pulse timing,
  // stall length, write count and load result.
  task automatic run_vec(input vec_t v);
    int k;
    int stall_cnt, web_cnt, ldv_cnt, ldv_at, sd_cnt, sd_at, ma_cnt, ma_at, both;
    logic [31:0] got_data;
    logic [4:0]  got_rd;
    k = v.kind;
`ifdef MAU_BYTE_WE_EN
    if (k == K_RMW) k = K_SW;
`endif
    stall_cnt = 0; web_cnt = 0; ldv_cnt = 0; ldv_at = 0; sd_cnt = 0; sd_at = 0;
    ma_cnt = 0; ma_at = 0; both = 0; got_data = '0; got_rd = '0;

    @(negedge clk);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    #1;
    check("accept_stall", {31'd0, stall}, 32'd0);
    check("idle_sram_addr", {27'd0, sram_addr}, {27'd0, v.addr[6:2]});
    if (!sram_web) web_cnt++;

    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      #1;
      if (stall)     stall_cnt++;
      if (!sram_web) web_cnt++;
      if (ld_valid) begin ldv_cnt++; ldv_at = c; got_data = ld_data; got_rd = ld_rd; end
      if (st_done)  begin sd_cnt++;  sd_at = c; end
      if (misalign) begin ma_cnt++;  ma_at = c; end
      if (ld_valid && st_done) both++;
    end

    check("ld_valid_count", ldv_cnt, (k == K_LOAD) ? 1 : 0);
    check("st_done_count",  sd_cnt,  (k == K_SW || k == K_RMW) ? 1 : 0);
    check("misalign_count", ma_cnt,  (k == K_MIS) ? 1 : 0);
    check("pulse_overlap",  both, 0);
    check("stall_cycles",   stall_cnt, (k == K_LOAD) ? 1 : (k == K_RMW) ? 2 : 0);
    check("write_cycles",   web_cnt, (k == K_SW || k == K_RMW) ? 1 : 0);
    case (k)
      K_LOAD: begin
        check("ld_valid_cycle", ldv_at, 2);
        check("ld_data", got_data, v.exp);
        check("ld_rd", {27'd0, got_rd}, {27'd0, v.rd});
      end
      K_SW:  check("st_done_cycle", sd_at, 1);
      K_RMW: check("st_done_cycle", sd_at, 3);
      default: check("misalign_cycle", ma_at, 1);
    endcase
  endtask

  vec_t tbl[$];
  int   web_seen, sd_seen;

  initial begin
    rst = 1'b0; req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF; req_rd = 5'd0;

    // Reset held for two cycles with an SW request pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rst_web",      {31'd0, sram_web}, 32'd1);
      check("rst_stall",    {31'd0, stall},    32'd0);
      check("rst_pulses",   {29'd0, ld_valid, st_done, misalign}, 32'd0);
      check("rst_ld_data",  ld_data, 32'd0);
      check("rst_ld_rd",    {27'd0, ld_rd}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    check("rst_no_write", mem[16], 32'd0);

    //            st    f3      addr      wdata         rd     kind    expected
    tbl.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0,  K_SW,   32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0,        5'd1,  K_LOAD, 32'hDEADBEEF));
    tbl.push_back(mk(1, 3'b000, 32'h11, 32'hAAAAAA55, 5'd0,  K_RMW,  32'h0));
    tbl.push_back(mk(0, 3'b000, 32'h11, 32'h0,        5'd2,  K_LOAD, 32'h00000055));
    tbl.push_back(mk(0, 3'b100, 32'h13, 32'h0,        5'd3,  K_LOAD, 32'h000000DE));
    tbl.push_back(mk(0, 3'b001, 32'h12, 32'h0,        5'd4,  K_LOAD, 32'hFFFFDEAD));
    tbl.push_back(mk(0, 3'b101, 32'h12, 32'h0,        5'd5,  K_LOAD, 32'h0000DEAD));
    tbl.push_back(mk(0, 3'b010, 32'h13, 32'h0,        5'd6,  K_MIS,  32'h0));
    tbl.push_back(mk(1, 3'b001, 32'h11, 32'h0000FFFF, 5'd0,  K_MIS,  32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h10, 32'h0,        5'd7,  K_LOAD, 32'hDEAD55EF));
    tbl.push_back(mk(1, 3'b000, 32'h03, 32'h00000080, 5'd0,  K_RMW,  32'h0));
    tbl.push_back(mk(0, 3'b000, 32'h03, 32'h0,        5'd8,  K_LOAD, 32'hFFFFFF80));
    tbl.push_back(mk(0, 3'b100, 32'h03, 32'h0,        5'd9,  K_LOAD, 32'h00000080));
    tbl.push_back(mk(1, 3'b001, 32'h02, 32'h1234BEEF, 5'd0,  K_RMW,  32'h0));
    tbl.push_back(mk(0, 3'b001, 32'h02, 32'h0,        5'd10, K_LOAD, 32'hFFFFBEEF));
    tbl.push_back(mk(0, 3'b101, 32'h00, 32'h0,        5'd11, K_LOAD, 32'h00000000));
    tbl.push_back(mk(1, 3'b010, 32'h84, 32'h12345678, 5'd0,  K_SW,   32'h0));
    tbl.push_back(mk(0, 3'b010, 32'h04, 32'h0,        5'd12, K_LOAD, 32'h12345678));
    tbl.push_back(mk(1, 3'b011, 32'h08, 32'hCAFEF00D, 5'd0,  K_SW,   32'h0));
    tbl.push_back(mk(0, 3'b011, 32'h08, 32'h0,        5'd13, K_LOAD, 32'hCAFEF00D));
    tbl.push_back(mk(0, 3'b111, 32'h09, 32'h0,        5'd14, K_MIS,  32'h0));
    tbl.push_back(mk(0, 3'b000, 32'h0A, 32'h0,        5'd15, K_LOAD, 32'hFFFFFFFE));
    tbl.push_back(mk(1, 3'b010, 32'h20, 32'h11111111, 5'd0,  K_SW,   32'h0));

    foreach (tbl[i]) run_vec(tbl[i]);

    check("mem_word4", mem[4], 32'hDEAD55EF);
    check("mem_word0", mem[0], 32'hBEEF0000);
    check("mem_word1", mem[1], 32'h12345678);

`ifdef MAU_BYTE_WE_EN
    // SH through the byte mask: single cycle, data replicated, no stall.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h22; req_wdata = 32'h00001234;
    #1;
    check("bwe_wmask", {28'd0, sram_wmask}, 32'hC);
    check("bwe_din",   sram_din, 32'h12341234);
    check("bwe_web",   {31'd0, sram_web}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; #1;
    check("bwe_st_done", {31'd0, st_done}, 32'd1);
    check("bwe_stall",   {31'd0, stall},   32'd0);
    check("bwe_mem",     mem[8], 32'h12341111);
    run_vec(mk(0, 3'b010, 32'h20, 32'h0, 5'd16, K_LOAD, 32'h12341111));
`else
    // Reset asserted while an SB sits in RMW_WAIT: no write may follow.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h20; req_wdata = 32'h00000099;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0; #1;
    check("abort_in_rmw_stall", {31'd0, stall}, 32'd1);
    web_seen = 0; sd_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      #1;
      if (!sram_web) web_seen++;
      if (st_done)   sd_seen++;
      @(negedge clk);
    end
    #1;
    check("abort_no_write",   web_seen, 0);
    check("abort_no_st_done", sd_seen, 0);
    check("abort_idle",       {31'd0, stall}, 32'd0);
    check("abort_mem",        mem[8], 32'h11111111);
    run_vec(mk(0, 3'b010, 32'h20, 32'h0, 5'd16, K_LOAD, 32'h11111111));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the execute stage and the 32x32 word-only data SRAM of the RISC-V pipeline.
- Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into SRAM word accesses.
- Sub-word stores use an internal read-modify-write (RMW) sequence.
- Loads are sign- or zero-extended, misalignment is detected, and the upstream stage is stalled while the unit is busy.

Parameters:
- ADDR_WIDTH, 5, SRAM word-address width; word index = addr[ADDR_WIDTH+1:2].
- DATA_WIDTH, 32, fixed word width; only 32 is supported.

Ports:
- clk  in  1  clock; rising edge; single clock domain.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present; accepted only when state = IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_rd  in  5  load destination register.
- stall  out  1  high while state != IDLE; upstream holds its request.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_din  out  32  SRAM write data.
- sram_web  out  1  SRAM write enable, active-low.
- sram_dout  in  32  SRAM read data; valid one cycle after the address is presented.
- ld_valid  out  1  one-cycle pulse: load result ready.
- ld_data  out  32  extended load result.
- ld_rd  out  5  destination register of the load.
- st_done  out  1  one-cycle pulse: store committed to SRAM.
- misalign  out  1  one-cycle pulse: request rejected as misaligned.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state <= IDLE.
  - ld_valid, st_done, misalign <= 0; ld_data, ld_rd <= 0.
  - sram_web = 1.
  - Any in-flight RMW is aborted; no SRAM write is issued.
- FSM states: IDLE, LOAD_WAIT, RMW_WAIT, RMW_WRITE.
- SRAM outputs:
  - sram_addr = req_addr[ADDR_WIDTH+1:2] in IDLE; latched address otherwise.
  - Addresses beyond the SRAM size wrap (upper bits ignored).
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - The request is accepted but no SRAM access occurs.
  - misalign=1 in the next cycle; state stays IDLE.
- Unsupported funct3 (011, 110, 111) is treated as a word access.
- LW/LH/LHU/LB/LBU, accepted at T0:
  - T0: addr presented; go to LOAD_WAIT; latch offset, funct3 and rd.
  - T1: stall=1; select lane from sram_dout; sign-extend (B/H) or zero-extend (BU/HU); register into ld_data; go to IDLE.
  - T2: ld_valid=1, ld_rd valid; stall=0, so a new request can be accepted.
  - Lanes: byte k = bits [8k+7:8k]; halfword uses offset[1].
- SW, accepted at T0: sram_web=0 and sram_din=req_wdata in T0; st_done=1 at T1; no stall.
- SB/SH, accepted at T0:
  - T0: read issued; latch addr, offset and data; go to RMW_WAIT.
  - T1: stall=1; merge the new byte/halfword into sram_dout and register it; go to RMW_WRITE.
  - T2: stall=1; sram_web=0, sram_din=merged word; go to IDLE.
  - T3: st_done=1.
- Pulses never last more than one cycle. ld_valid and st_done are never high together.
- req_valid is ignored while stall=1 (upstream holds the request).

Optional Feature:
- Macro MAU_BYTE_WE_EN.
- Defined:
  - Adds output port sram_wmask[3:0], which drives the SRAM byte-write mask.
  - SB/SH complete in a single cycle like SW: mask 0001<<offset for SB, 0011<<offset for SH; data replicated into every lane.
  - RMW states are unused; no stall on any store.
  - Loads, and all accesses outside sub-word stores, drive sram_wmask=1111.
- Undefined: port absent; RMW sequence as above.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=1 SW -> sram_web=1 throughout; all pulses 0; stall=0.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> st_done at T1. Then, counting from the LW accept: sram_addr=4; ld_valid two cycles later; ld_data=0xDEADBEEF; stall high for one cycle.
- After the word above: SB 0x55 @0x11, LB @0x11, LBU @0x13 ->
  - stall high 2 cycles;
  - SRAM word becomes 0xDEAD55EF;
  - LB returns 0x00000055;
  - LBU returns 0x000000DE.
- LH @0x12 on word 0xDEAD55EF -> 0xFFFFDEAD; LHU -> 0x0000DEAD.
- LW @0x13, SH @0x11 -> misalign pulse each, no sram_web=0 cycle, stall stays 0, memory unchanged.
- rst=0 asserted in RMW_WAIT of SB @0x20 -> no write occurs; word at 0x20 keeps its old value; state IDLE after reset.
- With MAU_BYTE_WE_EN: SH 0x1234 @0x22 -> sram_wmask=1100, sram_din=0x12341234, st_done next cycle, stall never high.
